apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter_if.sv | 30 +++
 rtl/apb_req_arbiter.sv | 111 +++++++++++
 tb/tb_apb_req_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester-side and APB-side signals of the two-port APB request arbiter.
// master = the arbiter (APB master), slave = requesters plus APB completer around it.
interface apb_req_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [2:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1;
  logic [31:0] rdata;
  logic        err;
  logic        PSEL, PENABLE, PWRITE;
  logic [2:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  PREADY, PSLVERR, PRDATA,
    output done0, done1, rdata, err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output PREADY, PSLVERR, PRDATA,
    input  done0, done1, rdata, err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbitration of two level requesters onto one APB master port.
// Optional APB_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES clocks (err=1, rdata=0).
module apb_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  apb_req_arbiter_if.master bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]  r_state;
  logic        r_ptr;      // requester served last
  logic        r_win;      // requester owning the transfer in flight
  logic        r_psel, r_penable, r_pwrite;
  logic [2:0]  r_paddr;
  logic [31:0] r_pwdata, r_rdata;
  logic        r_err, r_done0, r_done1;

  logic        w_any, w_win, w_timeout, w_finish;

  assign w_any = bus.req0 | bus.req1;
  // Under contention the pointer decides; a lone request always wins.
  assign w_win = (bus.req0 & bus.req1) ? ~r_ptr : bus.req1;

`ifdef APB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_cnt;

  assign w_timeout = (r_state == S_ACCESS) && !bus.PREADY &&
                     (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_cnt <= '0;
    else if (r_state == S_SETUP)                    r_cnt <= '0;
    else if (r_state == S_ACCESS && !bus.PREADY)    r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_finish = (r_state == S_ACCESS) && (bus.PREADY || w_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b1;
      r_win     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win     <= w_win;
            r_pwrite  <= w_win ? bus.we1    : bus.we0;
            r_paddr   <= w_win ? bus.addr1  : bus.addr0;
            r_pwdata  <= w_win ? bus.wdata1 : bus.wdata0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_finish) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ptr     <= r_win;
            r_done0   <= ~r_win;
            r_done1   <= r_win;
            r_err     <= bus.PREADY ? bus.PSLVERR : 1'b1;
            // Timeout forces rdata to 0; a completed write leaves it untouched.
            if (!bus.PREADY)    r_rdata <= '0;
            else if (!r_pwrite) r_rdata <= bus.PRDATA;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PSEL    = r_psel;
  assign bus.PENABLE = r_penable;
  assign bus.PWRITE  = r_pwrite;
  assign bus.PADDR   = r_paddr;
  assign bus.PWDATA  = r_pwdata;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: table vectors, hand-written corner sequences and random traffic,
// all cross-checked every cycle against a transaction-age reference model.
module tb_apb_req_arbiter;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  apb_req_arbiter_if bus();
  apb_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errs   = 0;
  int checks = 0;

  // reference model: who owns the bus, how many cycles since the grant
  bit          m_last, m_busy, m_w, m_we, m_err, m_d0, m_d1;
  int          m_age;
  logic [2:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  typedef struct {
    bit r0, r1, we0, we1;
    logic [2:0] a0, a1;
    logic [31:0] d0, d1;
    int wait_n;
    logic [31:0] prd;
    bit slv;
    bit e_win, e_we;
    logic [2:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
    bit e_err;
    int e_psel;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_last = 1'b1; m_busy = 0; m_w = 0; m_we = 0; m_err = 0; m_d0 = 0; m_d1 = 0;
    m_age = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
  endfunction

  function automatic void model_finish(input bit rdy, input bit slv, input logic [31:0] prd);
    if (m_w) m_d1 = 1'b1; else m_d0 = 1'b1;
    m_err = rdy ? slv : 1'b1;
    if (!rdy) m_rdata = '0;
    else if (!m_we) m_rdata = prd;
    m_last = m_w;
    m_busy = 1'b0;
  endfunction

  task automatic cmp_model();
    check("model_ctrl",
          64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.done0, bus.done1, bus.err}),
          64'({m_busy, (m_busy && m_age >= 1), m_we, m_addr, m_d0, m_d1, m_err}));
    check("model_pwdata", 64'(bus.PWDATA), 64'(m_wdata));
    check("model_rdata",  64'(bus.rdata),  64'(m_rdata));
  endtask

  // One clock: snapshot what the DUT will sample, advance, update model, compare.
  task automatic tick();
    bit s_r0, s_r1, s_we0, s_we1, s_rdy, s_slv;
    logic [2:0] s_a0, s_a1;
    logic [31:0] s_d0, s_d1, s_prd;
    s_r0 = bus.req0; s_r1 = bus.req1; s_we0 = bus.we0; s_we1 = bus.we1;
    s_a0 = bus.addr0; s_a1 = bus.addr1; s_d0 = bus.wdata0; s_d1 = bus.wdata1;
    s_rdy = bus.PREADY; s_slv = bus.PSLVERR; s_prd = bus.PRDATA;
    @(posedge clk); #1;
    m_d0 = 0; m_d1 = 0;
    if (m_busy) begin
      if (m_age >= 1 && s_rdy) model_finish(1'b1, s_slv, s_prd);
`ifdef APB_TIMEOUT_EN
      else if (m_age >= TO) model_finish(1'b0, 1'b0, '0);
`endif
      else m_age++;
    end else if (s_r0 || s_r1) begin
      m_w     = (s_r0 && s_r1) ? !m_last : s_r1;
      m_we    = m_w ? s_we1 : s_we0;
      m_addr  = m_w ? s_a1  : s_a0;
      m_wdata = m_w ? s_d1  : s_d0;
      m_busy  = 1'b1;
      m_age   = 0;
    end
    cmp_model();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_done(output bit got);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (bus.done0 || bus.done1) got = 1;
    end
    if (!got) check("done_bound", 64'(got), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int psel_n, pen_n, acc;
    bit got;
    psel_n = 0; pen_n = 0; acc = 0; got = 0;
    bus.req0 = v.r0; bus.req1 = v.r1; bus.we0 = v.we0; bus.we1 = v.we1;
    bus.addr0 = v.a0; bus.addr1 = v.a1; bus.wdata0 = v.d0; bus.wdata1 = v.d1;
    bus.PREADY = 1'b0; bus.PRDATA = v.prd; bus.PSLVERR = v.slv;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (bus.PSEL) psel_n++;
      if (bus.PENABLE) pen_n++;
      if (bus.PSEL && !bus.PENABLE)
        check("vec_setup", 64'({bus.PWRITE, bus.PADDR, bus.PWDATA}),
              64'({v.e_we, v.e_addr, v.e_wdata}));
      if (bus.done0 || bus.done1) begin
        got = 1;
        check("vec_done", 64'({bus.done1, bus.done0}), v.e_win ? 64'd2 : 64'd1);
        check("vec_rdata", 64'(bus.rdata), 64'(v.e_rdata));
        check("vec_err", 64'(bus.err), 64'(v.e_err));
        check("vec_psel_cycles", 64'(psel_n), 64'(v.e_psel));
        check("vec_penable_cycles", 64'(pen_n), 64'(v.e_psel - 1));
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      if (bus.PENABLE) acc++;
      bus.PREADY = bus.PENABLE && (acc == v.wait_n + 1);
    end
    if (!got) check("vec_bound", 64'(got), 64'd1);
    bus.PREADY = 1'b0;
    tick();
    check("vec_pulse_width", 64'({bus.done1, bus.done0}), 64'd0);
  endtask

  task automatic rnd_fields(input bit which);
    if (!which) begin
      bus.we0 = 1'($urandom_range(0, 1)); bus.addr0 = 3'($urandom_range(0, 7)); bus.wdata0 = $urandom;
    end else begin
      bus.we1 = 1'($urandom_range(0, 1)); bus.addr1 = 3'($urandom_range(0, 7)); bus.wdata1 = $urandom;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int n, d, seq;
    bit got;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.PREADY = 0; bus.PSLVERR = 0; bus.PRDATA = '0;

    //        r0 r1 we0 we1 a0 a1 d0            d1             w  prd             slv win we ad  wdata          rdata          err psel
    vecs[0] = '{1, 0, 0, 0, 3, 0, 32'h0,        32'h0,         1, 32'h0000000A,   0,  0,  0, 3, 32'h0,         32'h0000000A,  0,  3};
    vecs[1] = '{1, 1, 1, 0, 1, 2, 32'h11,       32'h99,        0, 32'h22,         0,  1,  0, 2, 32'h99,        32'h22,        0,  2};
    vecs[2] = '{1, 1, 1, 0, 5, 6, 32'hDEADBEEF, 32'h0,         2, 32'h33,         0,  0,  1, 5, 32'hDEADBEEF,  32'h22,        0,  4};
    vecs[3] = '{0, 1, 0, 1, 0, 7, 32'h0,        32'h5A5A5A5A,  0, 32'h44,         1,  1,  1, 7, 32'h5A5A5A5A,  32'h22,        1,  2};
    vecs[4] = '{1, 1, 0, 1, 0, 1, 32'h1,        32'h2,         1, 32'h12345678,   1,  0,  0, 0, 32'h1,         32'h12345678,  1,  3};
    vecs[5] = '{1, 0, 0, 0, 6, 0, 32'h0,        32'h0,         3, 32'hCAFEF00D,   0,  0,  0, 6, 32'h0,         32'hCAFEF00D,  0,  5};
    vecs[6] = '{1, 1, 0, 1, 1, 2, 32'h0,        32'h77,        0, 32'h55,         0,  1,  1, 2, 32'h77,        32'hCAFEF00D,  0,  2};

    #2;
    apply_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // contention held from reset: 0, 1, 0
    apply_reset();
    bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0; bus.addr0 = 3'd1; bus.addr1 = 3'd2;
    bus.PREADY = 1; bus.PRDATA = 32'h100; bus.PSLVERR = 0;
    for (int c = 0; c < 40 && order.size() < 3; c++) begin
      tick();
      if (bus.done0) order.push_back(0);
      if (bus.done1) order.push_back(1);
    end
    bus.req0 = 0; bus.req1 = 0;
    check("cont_count", 64'(order.size()), 64'd3);
    seq = 0;
    foreach (order[k]) seq = seq * 2 + order[k];
    check("cont_order", 64'(seq), 64'd2);

    // in-flight transfer ignores winner dropping req and any field changes
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd3; bus.wdata0 = '0;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 3'd4; bus.wdata1 = 32'h600D;
    bus.PREADY = 0;
    tick();
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 3'd1; bus.wdata1 = 32'hBAD; bus.we0 = 1; bus.addr0 = 3'd5;
    tick(); tick();
    check("hold_fields", 64'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 64'({1'b1, 3'd4, 32'h600D}));
    bus.PREADY = 1;
    tick();
    check("hold_done1", 64'({bus.done1, bus.done0}), 64'd2);
    bus.req0 = 0; bus.PREADY = 0;
    tick();

    // reset mid-ACCESS after requester 0 was served last
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd2; bus.PRDATA = 32'h0BADF00D; bus.PREADY = 1;
    run_until_done(got);
    bus.req0 = 0;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 3'd6; bus.wdata1 = 32'h1234; bus.PREADY = 0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.done0, bus.done1, bus.err}), 64'd0);
    check("rst_async_data", 64'({bus.PWDATA, bus.rdata}), 64'd0);
    bus.req1 = 0;
    apply_reset();
    bus.PREADY = 1;
    d = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done0 || bus.done1) d++;
    end
    check("rst_no_done", 64'(d), 64'd0);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd1; bus.req1 = 1; bus.we1 = 1; bus.addr1 = 3'd5;
    tick();
    check("rst_first_win", 64'(bus.PADDR), 64'd1);
    run_until_done(got);
    check("rst_first_done", 64'({bus.done1, bus.done0}), 64'd1);
    bus.req0 = 0; bus.req1 = 0;

    // ACCESS with PREADY held low
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd3; bus.PREADY = 0; bus.PRDATA = 32'h77;
    tick();
    n = 0; d = 0; got = 0;
`ifdef APB_TIMEOUT_EN
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (bus.PENABLE) n++;
      if (bus.done0) got = 1;
    end
    check("to_done", 64'(got), 64'd1);
    check("to_access_cycles", 64'(n), 64'(TO));
    check("to_err", 64'(bus.err), 64'd1);
    check("to_rdata", 64'(bus.rdata), 64'd0);
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.PSEL) n++;
      if (bus.done0 || bus.done1) d++;
    end
    check("nt_psel_held", 64'(n), 64'd100);
    check("nt_no_done", 64'(d), 64'd0);
    bus.PREADY = 1;
    tick();
    check("nt_late_done", 64'({bus.done1, bus.done0}), 64'd1);
`endif
    bus.req0 = 0; bus.PREADY = 0;
    tick();

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (m_d0) begin
        bus.req0 = ($urandom_range(0, 3) == 0);
        if (bus.req0) rnd_fields(0);
      end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1; rnd_fields(0);
      end
      if (m_d1) begin
        bus.req1 = ($urandom_range(0, 3) == 0);
        if (bus.req1) rnd_fields(1);
      end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1; rnd_fields(1);
      end
      bus.PREADY  = ($urandom_range(0, 2) != 0);
      bus.PRDATA  = $urandom;
      bus.PSLVERR = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.req0 = 0; bus.req1 = 0; bus.PREADY = 1;
    for (int c = 0; c < 8; c++) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
